// File: rtl/id_r_pipe_pkg.sv
// Shared decode constants for the R-type decode pipe: opcodes, funct codes,
// internal instruction codes and the per-entry field bundle.
package id_r_pipe_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned REG_W  = 5;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MOVZ    = 6'h0a;
  localparam logic [5:0] FN_MOVN    = 6'h0b;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_BREAK   = 6'h0d;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2a;
  localparam logic [5:0] FN_SLTU    = 6'h2b;

  localparam logic [5:0] FN2_MUL = 6'h02;
  localparam logic [5:0] FN2_CLZ = 6'h20;
  localparam logic [5:0] FN2_CLO = 6'h21;

  // INVALID is zero so a cleared entry reads back as INVALID.
  localparam logic [CODE_W-1:0] INST_INVALID = 8'd0;
  localparam logic [CODE_W-1:0] INST_SLL     = 8'd1;
  localparam logic [CODE_W-1:0] INST_SRL     = 8'd2;
  localparam logic [CODE_W-1:0] INST_SRA     = 8'd3;
  localparam logic [CODE_W-1:0] INST_SLLV    = 8'd4;
  localparam logic [CODE_W-1:0] INST_SRLV    = 8'd5;
  localparam logic [CODE_W-1:0] INST_SRAV    = 8'd6;
  localparam logic [CODE_W-1:0] INST_JR      = 8'd7;
  localparam logic [CODE_W-1:0] INST_JALR    = 8'd8;
  localparam logic [CODE_W-1:0] INST_MOVZ    = 8'd9;
  localparam logic [CODE_W-1:0] INST_MOVN    = 8'd10;
  localparam logic [CODE_W-1:0] INST_SYSCALL = 8'd11;
  localparam logic [CODE_W-1:0] INST_BREAK   = 8'd12;
  localparam logic [CODE_W-1:0] INST_MFHI    = 8'd13;
  localparam logic [CODE_W-1:0] INST_MTHI    = 8'd14;
  localparam logic [CODE_W-1:0] INST_MFLO    = 8'd15;
  localparam logic [CODE_W-1:0] INST_MTLO    = 8'd16;
  localparam logic [CODE_W-1:0] INST_MULT    = 8'd17;
  localparam logic [CODE_W-1:0] INST_MULTU   = 8'd18;
  localparam logic [CODE_W-1:0] INST_DIV     = 8'd19;
  localparam logic [CODE_W-1:0] INST_DIVU    = 8'd20;
  localparam logic [CODE_W-1:0] INST_ADD     = 8'd21;
  localparam logic [CODE_W-1:0] INST_ADDU    = 8'd22;
  localparam logic [CODE_W-1:0] INST_SUB     = 8'd23;
  localparam logic [CODE_W-1:0] INST_SUBU    = 8'd24;
  localparam logic [CODE_W-1:0] INST_AND     = 8'd25;
  localparam logic [CODE_W-1:0] INST_OR      = 8'd26;
  localparam logic [CODE_W-1:0] INST_XOR     = 8'd27;
  localparam logic [CODE_W-1:0] INST_NOR     = 8'd28;
  localparam logic [CODE_W-1:0] INST_SLT     = 8'd29;
  localparam logic [CODE_W-1:0] INST_SLTU    = 8'd30;
  localparam logic [CODE_W-1:0] INST_MUL     = 8'd31;
  localparam logic [CODE_W-1:0] INST_CLZ     = 8'd32;
  localparam logic [CODE_W-1:0] INST_CLO     = 8'd33;

  typedef struct packed {
    logic [REG_W-1:0] reg_s;
    logic [REG_W-1:0] reg_t;
    logic [REG_W-1:0] reg_d;
    logic [REG_W-1:0] shift;
    logic             invalid;
  } fields_t;

  function automatic logic [CODE_W-1:0] special_lookup(input logic [5:0] funct);
    logic [CODE_W-1:0] r;
    case (funct)
      FN_SLL:     r = INST_SLL;
      FN_SRL:     r = INST_SRL;
      FN_SRA:     r = INST_SRA;
      FN_SLLV:    r = INST_SLLV;
      FN_SRLV:    r = INST_SRLV;
      FN_SRAV:    r = INST_SRAV;
      FN_JR:      r = INST_JR;
      FN_JALR:    r = INST_JALR;
      FN_MOVZ:    r = INST_MOVZ;
      FN_MOVN:    r = INST_MOVN;
      FN_SYSCALL: r = INST_SYSCALL;
      FN_BREAK:   r = INST_BREAK;
      FN_MFHI:    r = INST_MFHI;
      FN_MTHI:    r = INST_MTHI;
      FN_MFLO:    r = INST_MFLO;
      FN_MTLO:    r = INST_MTLO;
      FN_MULT:    r = INST_MULT;
      FN_MULTU:   r = INST_MULTU;
      FN_DIV:     r = INST_DIV;
      FN_DIVU:    r = INST_DIVU;
      FN_ADD:     r = INST_ADD;
      FN_ADDU:    r = INST_ADDU;
      FN_SUB:     r = INST_SUB;
      FN_SUBU:    r = INST_SUBU;
      FN_AND:     r = INST_AND;
      FN_OR:      r = INST_OR;
      FN_XOR:     r = INST_XOR;
      FN_NOR:     r = INST_NOR;
      FN_SLT:     r = INST_SLT;
      FN_SLTU:    r = INST_SLTU;
      default:    r = INST_INVALID;
    endcase
    return r;
  endfunction

  function automatic logic [CODE_W-1:0] special2_lookup(input logic [5:0] funct);
    logic [CODE_W-1:0] r;
    case (funct)
      FN2_MUL: r = INST_MUL;
      FN2_CLZ: r = INST_CLZ;
      FN2_CLO: r = INST_CLO;
      default: r = INST_INVALID;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_r_dec.sv
// Combinational R-type decoder: opcode/funct to instruction code, register
// fields extracted, optional zero-field enforcement.
module id_r_dec
  import id_r_pipe_pkg::*;
#(
  parameter int unsigned INST_W      = 8,
  parameter bit          SPECIAL2_EN = 1'b1,
  parameter bit          STRICT      = 1'b0
) (
  input  logic [31:0]       inst_code,
  output logic [INST_W-1:0] inst_c,
  output fields_t           fields_c
);

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  sa;
  logic [CODE_W-1:0] code;
  logic              strict_bad;

  assign op    = inst_code[31:26];
  assign rs    = inst_code[25:21];
  assign rt    = inst_code[20:16];
  assign rd    = inst_code[15:11];
  assign sa    = inst_code[10:6];
  assign funct = inst_code[5:0];

  always_comb begin
    code       = INST_INVALID;
    strict_bad = 1'b0;
    if (op == OP_SPECIAL) begin
      code = special_lookup(funct);
    end else if (SPECIAL2_EN && (op == OP_SPECIAL2)) begin
      code = special2_lookup(funct);
    end
    // Fields that must be zero for a well-formed encoding of these ops.
    if (STRICT) begin
      case (code)
        INST_SLL, INST_SRL, INST_SRA:            strict_bad = (rs != '0);
        INST_MFHI, INST_MFLO:                    strict_bad = ((rs | rt) != '0);
        INST_JR:                                 strict_bad = ((rt | rd) != '0);
        INST_MULT, INST_MULTU, INST_DIV, INST_DIVU: strict_bad = (rd != '0);
        default:                                 strict_bad = 1'b0;
      endcase
    end
    if (strict_bad) begin
      code = INST_INVALID;
    end
  end

  always_comb begin
    inst_c           = INST_W'(code);
    fields_c.reg_s   = rs;
    fields_c.reg_t   = rt;
    fields_c.reg_d   = rd;
    fields_c.shift   = sa;
    fields_c.invalid = (code == INST_INVALID);
  end

endmodule

// File: rtl/id_r_pipe.sv
// Decode stage with a 2-entry output FIFO and valid/ready handshakes on
// both sides; outputs are driven straight from the head entry's flops.
module id_r_pipe
  import id_r_pipe_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned INST_W      = 8,
  parameter bit          SPECIAL2_EN = 1'b1,
  parameter bit          STRICT      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst_code,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [4:0]        out_reg_s,
  output logic [4:0]        out_reg_t,
  output logic [4:0]        out_reg_d,
  output logic [4:0]        out_shift,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_invalid
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic [INST_W-1:0] dec_inst;
  fields_t           dec_fields;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [INST_W-1:0] inst_d [DEPTH];
  fields_t           fld_q  [DEPTH];
  fields_t           fld_d  [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [PC_W-1:0]   pc_d   [DEPTH];
  logic              push;
  logic              pop;

  id_r_dec #(
    .INST_W      (INST_W),
    .SPECIAL2_EN (SPECIAL2_EN),
    .STRICT      (STRICT)
  ) u_dec (
    .inst_code (in_inst_code),
    .inst_c    (dec_inst),
    .fields_c  (dec_fields)
  );

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  // A flush swallows the same-cycle input; a same-cycle pop still completes.
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    inst_d   = inst_q;
    fld_d    = fld_q;
    pc_d     = pc_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        inst_d[wr_ptr_q] = dec_inst;
        fld_d[wr_ptr_q]  = dec_fields;
        pc_d[wr_ptr_q]   = in_pc;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        fld_q[i]  <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      inst_q   <= inst_d;
      fld_q    <= fld_d;
      pc_q     <= pc_d;
    end
  end

  always_comb begin
    out_inst    = inst_q[rd_ptr_q];
    out_reg_s   = fld_q[rd_ptr_q].reg_s;
    out_reg_t   = fld_q[rd_ptr_q].reg_t;
    out_reg_d   = fld_q[rd_ptr_q].reg_d;
    out_shift   = fld_q[rd_ptr_q].shift;
    out_invalid = fld_q[rd_ptr_q].invalid;
    out_pc      = pc_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_id_r_pipe.sv
// Scoreboard bench for id_r_pipe: two instances (SPECIAL2 on/STRICT off and
// SPECIAL2 off/STRICT on) share stimulus and are checked against a reference decode.
module tb_id_r_pipe;
  import id_r_pipe_pkg::*;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [31:0]       in_inst_code = '0;
  logic [PC_W-1:0]   in_pc = '0;

  logic              in_ready_a, out_valid_a, out_invalid_a;
  logic [INST_W-1:0] out_inst_a;
  logic [4:0]        s_a, t_a, d_a, sh_a;
  logic [PC_W-1:0]   pc_a;
  logic              in_ready_b, out_valid_b, out_invalid_b;
  logic [INST_W-1:0] out_inst_b;
  logic [4:0]        s_b, t_b, d_b, sh_b;
  logic [PC_W-1:0]   pc_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]      inst_a;
    logic            inv_a;
    logic [7:0]      inst_b;
    logic            inv_b;
    logic [4:0]      s, t, d, sh;
    logic [PC_W-1:0] pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  id_r_pipe #(.PC_W(PC_W), .INST_W(INST_W), .SPECIAL2_EN(1'b1), .STRICT(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst_code(in_inst_code), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_inst(out_inst_a), .out_reg_s(s_a), .out_reg_t(t_a), .out_reg_d(d_a), .out_shift(sh_a),
    .out_pc(pc_a), .out_invalid(out_invalid_a));

  id_r_pipe #(.PC_W(PC_W), .INST_W(INST_W), .SPECIAL2_EN(1'b0), .STRICT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst_code(in_inst_code), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_inst(out_inst_b), .out_reg_s(s_b), .out_reg_t(t_b), .out_reg_d(d_b), .out_shift(sh_b),
    .out_pc(pc_b), .out_invalid(out_invalid_b));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_inst(input logic [31:0] w, input bit s2, input bit strict);
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    logic [4:0] rs = w[25:21];
    logic [4:0] rt = w[20:16];
    logic [4:0] rd = w[15:11];
    logic [7:0] r  = INST_INVALID;
    if (op == 6'h00) begin
      case (fn)
        6'h00: r = INST_SLL;   6'h02: r = INST_SRL;   6'h03: r = INST_SRA;
        6'h04: r = INST_SLLV;  6'h06: r = INST_SRLV;  6'h07: r = INST_SRAV;
        6'h08: r = INST_JR;    6'h09: r = INST_JALR;  6'h0a: r = INST_MOVZ;
        6'h0b: r = INST_MOVN;  6'h0c: r = INST_SYSCALL; 6'h0d: r = INST_BREAK;
        6'h10: r = INST_MFHI;  6'h11: r = INST_MTHI;  6'h12: r = INST_MFLO;
        6'h13: r = INST_MTLO;  6'h18: r = INST_MULT;  6'h19: r = INST_MULTU;
        6'h1a: r = INST_DIV;   6'h1b: r = INST_DIVU;  6'h20: r = INST_ADD;
        6'h21: r = INST_ADDU;  6'h22: r = INST_SUB;   6'h23: r = INST_SUBU;
        6'h24: r = INST_AND;   6'h25: r = INST_OR;    6'h26: r = INST_XOR;
        6'h27: r = INST_NOR;   6'h2a: r = INST_SLT;   6'h2b: r = INST_SLTU;
        default: r = INST_INVALID;
      endcase
      if (strict) begin
        if ((fn == 6'h00 || fn == 6'h02 || fn == 6'h03) && rs != 5'd0) r = INST_INVALID;
        if ((fn == 6'h10 || fn == 6'h12) && (rs != 5'd0 || rt != 5'd0)) r = INST_INVALID;
        if (fn == 6'h08 && (rt != 5'd0 || rd != 5'd0)) r = INST_INVALID;
        if (fn >= 6'h18 && fn <= 6'h1b && rd != 5'd0) r = INST_INVALID;
      end
    end else if (op == 6'h1c && s2) begin
      case (fn)
        6'h02: r = INST_MUL;
        6'h20: r = INST_CLZ;
        6'h21: r = INST_CLO;
        default: r = INST_INVALID;
      endcase
    end
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] w, input logic [PC_W-1:0] p);
    exp_t e;
    e.inst_a = ref_inst(w, 1'b1, 1'b0);
    e.inv_a  = (e.inst_a == INST_INVALID);
    e.inst_b = ref_inst(w, 1'b0, 1'b1);
    e.inv_b  = (e.inst_b == INST_INVALID);
    e.s = w[25:21]; e.t = w[20:16]; e.d = w[15:11]; e.sh = w[10:6];
    e.pc = p;
    return e;
  endfunction

  function automatic logic [31:0] rand_code();
    logic [31:0] w = $urandom;
    int sel = $urandom_range(0, 19);
    if (sel < 14) w[31:26] = 6'h00;
    else if (sel < 17) w[31:26] = 6'h1c;
    if ($urandom_range(0, 1) == 1) w[25:21] = 5'd0;
    if ($urandom_range(0, 1) == 1) w[20:16] = 5'd0;
    if ($urandom_range(0, 1) == 1) w[15:11] = 5'd0;
    return w;
  endfunction

  // Scoreboard monitor: model count is the queue size.
  always @(negedge clk) begin
    exp_t e;
    int   sz;
    if (rst) begin
      sb.delete();
    end else begin
      sz = sb.size();
      check("out_valid", out_valid_a, sz != 0);
      check("in_ready", in_ready_a, sz != 2);
      check("out_valid_b", out_valid_b, sz != 0);
      check("in_ready_b", in_ready_b, sz != 2);
      if (out_valid_a && out_ready && sz != 0) begin
        e = sb.pop_front();
        check("inst_a", out_inst_a, e.inst_a);
        check("inv_a", out_invalid_a, e.inv_a);
        check("inst_b", out_inst_b, e.inst_b);
        check("inv_b", out_invalid_b, e.inv_b);
        check("reg_s", s_a, e.s);
        check("reg_t", t_a, e.t);
        check("reg_d", d_a, e.d);
        check("shift", sh_a, e.sh);
        check("pc", pc_a, e.pc);
        check("pc_b", pc_b, e.pc);
        check("shift_b", sh_b, e.sh);
      end
      if (flush) sb.delete();
      else if (in_valid && sz != 2) sb.push_back(mk_exp(in_inst_code, in_pc));
    end
  end

  task automatic send(input logic [31:0] c, input logic [PC_W-1:0] p);
    bit acc = 1'b0;
    in_valid = 1'b1; in_inst_code = c; in_pc = p;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready_a && !flush && !rst;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0; flush = 1'b0;
    for (int n = 0; n < 20 && (sb.size() != 0 || out_valid_a); n++) begin
      @(posedge clk); #1;
    end
    check("drain_valid", out_valid_a, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_out_inst", out_inst_a, INST_INVALID);
    check("rst_out_valid_b", out_valid_b, 1'b0);
    rst = 1'b0;

    // sub $8,$9,$10 with one-cycle latency
    out_ready = 1'b1;
    send(32'h012A4022, 32'h0000_1000);
    check("sub_valid", out_valid_a, 1'b1);
    check("sub_inst", out_inst_a, INST_SUB);
    check("sub_s", s_a, 5'd9);
    check("sub_t", t_a, 5'd10);
    check("sub_d", d_a, 5'd8);
    check("sub_inv", out_invalid_a, 1'b0);
    drain();

    // back-pressure: third ADDU is held until the consumer frees a slot
    out_ready = 1'b0;
    send(32'h01095021, 32'h0000_2000);
    send(32'h014B6021, 32'h0000_2004);
    check("full_in_ready", in_ready_a, 1'b0);
    fork
      send(32'h01AE7821, 32'h0000_2008);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("held_in_ready", in_ready_a, 1'b0);
        out_ready = 1'b1;
      end
    join
    drain();

    // SPECIAL2 MUL and STRICT sll
    send(32'h70001002, 32'h0000_3000);
    check("mul_a", out_inst_a, INST_MUL);
    check("mul_b_inv", out_invalid_b, 1'b1);
    drain();
    send(32'h00201080, 32'h0000_3004);
    check("sll_a", out_inst_a, INST_SLL);
    check("sll_shift", sh_a, 5'd2);
    check("sll_b_inv", out_invalid_b, 1'b1);
    drain();

    // flush while full, with a same-cycle input that must vanish
    out_ready = 1'b0;
    send(32'h01095021, 32'h0000_4000);
    send(32'h014B6021, 32'h0000_4004);
    in_valid = 1'b1; in_inst_code = 32'h012A4022; in_pc = 32'h0000_4008; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid_a, 1'b0);
    check("flush_ready", in_ready_a, 1'b1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_stays_empty", out_valid_a, 1'b0);

    // random streaming with a reset in the middle
    for (int cyc = 0; cyc < 1000; cyc++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_inst_code = rand_code();
      in_pc        = $urandom;
      out_ready    = $urandom_range(0, 1);
      flush        = ($urandom_range(0, 63) == 0);
      rst          = (cyc == 500);
      @(posedge clk); #1;
      if (cyc == 500) begin
        check("midrst_valid", out_valid_a, 1'b0);
        check("midrst_ready", in_ready_a, 1'b1);
        check("midrst_valid_b", out_valid_b, 1'b0);
      end
    end
    rst = 1'b0;
    drain();
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_r_pipe.md
ID_R_PIPE -- requirements
Module: id_r_pipe

Interface
REQ-001 Parameters SHALL be: PC_W, 32, width of passed-through PC; INST_W, 8, width of decoded opcode (matches `INST_* in defs.v); SPECIAL2_EN, 1, decode SPECIAL2 (opcode 6'b011100) when 1; STRICT, 0, enforce zero-field rules when 1.
REQ-002 Ports SHALL be: clk  in  1  single clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-003 flush  in  1  discard all buffered and incoming entries.
REQ-004 in_valid  in  1; in_ready  out  1; in_inst_code  in  32; in_pc  in  PC_W: upstream handshake and payload.
REQ-005 out_valid  out  1; out_ready  in  1; out_inst  out  INST_W; out_reg_s, out_reg_t, out_reg_d, out_shift  out  5 each; out_pc  out  PC_W; out_invalid  out  1: downstream handshake and payload.

Function
REQ-006 Transfer SHALL occur on a rising edge when valid and ready are both 1 on that side; no other cycle moves data.
REQ-007 Decode SHALL be combinational on in_inst_code; results SHALL be written into a 2-entry FIFO on input transfer; input-to-output latency is exactly 1 cycle when the FIFO is empty.
REQ-008 in_ready SHALL equal (count != 2); out_valid SHALL equal (count != 0); output fields SHALL come from the head entry, registered, no combinational in-to-out path.
REQ-009 count update: push only +1, pop only -1, push and pop in same cycle (count 1) unchanged; read/write pointers are 1 bit and wrap 1->0.
REQ-010 Output payload SHALL stay stable while out_valid=1 and out_ready=0.
REQ-011 reg fields SHALL be: s=[25:21], t=[20:16], d=[15:11], shift=[10:6]; out_pc = in_pc captured with same entry.
REQ-012 SPECIAL (op 0) funct map: 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV, 08 JR, 09 JALR, 0a MOVZ, 0b MOVN, 0c SYSCALL, 0d BREAK, 10 MFHI, 11 MTHI, 12 MFLO, 13 MTLO, 18 MULT, 19 MULTU, 1a DIV, 1b DIVU, 20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2a SLT, 2b SLTU.
REQ-013 SPECIAL2 funct map (only when SPECIAL2_EN=1): 02 MUL, 20 CLZ, 21 CLO.
REQ-014 Any other opcode/funct SHALL yield out_inst=`INST_INVALID and out_invalid=1; else out_invalid=0.
REQ-015 With STRICT=1: SLL/SRL/SRA with rs!=0, MFHI/MFLO with rs|rt!=0, JR with rt|rd!=0, MULT/MULTU/DIV/DIVU with rd!=0 SHALL be INVALID; with STRICT=0 these fields are ignored.
REQ-016 flush=1 SHALL set count, pointers to 0 next edge; an input transfer in the same cycle SHALL be dropped; an output pop in the same cycle still counts as delivered.
REQ-017 Entry order SHALL be preserved (FIFO); no entry duplicated or lost except by flush.

Reset
REQ-018 On rst=1 at an edge: count=0, pointers=0, so out_valid=0, in_ready=1 next cycle; rst SHALL override flush and any transfer.
REQ-019 After reset all stored payload SHALL be 0 and out_inst=`INST_INVALID; payload is don't-care to consumers while out_valid=0.
REQ-020 Reset mid-stream SHALL discard all buffered entries with no partial output.

Structure
REQ-021 `INST_* codes, opcode constants (SPECIAL=6'b000000, SPECIAL2=6'b011100) and funct constants SHALL live in shared defs.v.
REQ-022 Decode logic SHALL be a sub-module id_r_dec (pure combinational, same parameters); id_r_pipe holds FIFO and handshake.

Verification
REQ-023 Reset then in_inst_code=32'h012A4022 (sub $8,$9,$10), out_ready=1 -> next cycle out_valid=1, out_inst=`INST_SUB, s=9, t=10, d=8, out_invalid=0.
REQ-024 out_ready=0, push 3 back-to-back ADDU words -> in_ready=0 after 2nd transfer, 3rd held; release out_ready -> outputs in order, no loss.
REQ-025 in_inst_code=32'h70001002 with SPECIAL2_EN=0 -> `INST_INVALID, out_invalid=1; with SPECIAL2_EN=1 -> `INST_MUL.
REQ-026 STRICT=1, in_inst_code=32'h00201080 (sll, rs=1) -> out_invalid=1; STRICT=0 -> `INST_SLL, shift=2.
REQ-027 FIFO full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed-cycle input never appears.
REQ-028 Streaming with out_ready toggling randomly 1000 cycles, scoreboard vs. reference decode -> zero mismatches; rst asserted at cycle 500 empties FIFO within 1 cycle.
